wb_xcpt_retire: RTL
===================

// Module: wb_xcpt_retire
// PURPOSE
//  Write-back/retire stage: last pipeline stage, drives the decode-stage register-file write port
//  (writeEnRF/destRF/writeValRF) and exception-save port (xcpt_valid/rmPC/rmAddr).
//  Resolves exception priority across stages, issues a pipeline flush and PC redirect,
//  drains in-flight work via an FSM, and counts retired instructions.
// PARAMETERS
//  PC_WIDTH       32          PC / redirect width
//  DATA_WIDTH     32          RF data width
//  RF_ADDR_W      5           RF index width
//  XCPT_ADDR_W    32          faulting-address width (rmAddr)
//  XCPT_HANDLER   32'h2000    redirect PC on any exception
//  DRAIN_CYCLES   3           cycles inputs are dropped after a flush (stages behind WB)
// PORTS
//  clock            in   1            clock
//  reset            in   1            async reset, ACTIVE-LOW
//  wb_valid         in   1            retiring instruction present
//  wb_ready         out  1            1 only in RUN; wb_valid ignored when 0
//  wb_rf_wen        in   1            instruction writes RF
//  wb_rd            in   RF_ADDR_W    destination register
//  wb_data          in   DATA_WIDTH   result (ALU or load data)
//  wb_pc            in   PC_WIDTH     instruction PC
//  xcpt_fetch       in   1            fetch-stage fault (iTLB miss)
//  xcpt_fetch_addr  in   XCPT_ADDR_W  fetch fault address
//  xcpt_illegal     in   1            decode illegal-instruction
//  xcpt_overflow    in   1            ALU overflow
//  xcpt_dtlb        in   1            cache-stage dTLB miss
//  xcpt_dtlb_addr   in   XCPT_ADDR_W  data fault address
//  writeEnRF        out  1            RF write enable
//  destRF           out  RF_ADDR_W    RF write index
//  writeValRF       out  DATA_WIDTH   RF write data
//  xcpt_valid       out  1            one-cycle pulse: save rmPC/rmAddr
//  rmPC             out  PC_WIDTH     PC of faulting instruction
//  rmAddr           out  XCPT_ADDR_W  faulting address (0 if none)
//  flush_pipeline   out  1            flush fetch/decode/alu/cache
//  redirect_valid   out  1            fetch redirect pulse
//  redirect_pc      out  PC_WIDTH     = XCPT_HANDLER
//  retired_count    out  32           retired-instruction counter
// BEHAVIOUR
//  - Reset (reset==0, async): state=RUN, all outputs 0 except wb_ready=1, redirect_pc=XCPT_HANDLER.
//  - Accept = wb_valid & wb_ready. All outputs registered; 1-cycle latency from accept.
//  - Any-xcpt = OR of four xcpt_* inputs, sampled only on accept.
//  - Accept, no xcpt: next cycle writeEnRF=wb_rf_wen, destRF=wb_rd, writeValRF=wb_data;
//    retired_count+1 (wraps 2^32-1 -> 0). rd==0 written as supplied (no filtering).
//  - Accept with xcpt: no RF write, no count. Next cycle pulse xcpt_valid, flush_pipeline,
//    redirect_valid (1 cycle each); rmPC=wb_pc. Priority by program age, oldest stage first:
//    fetch > illegal > overflow > dtlb. rmAddr: fetch->xcpt_fetch_addr, dtlb->xcpt_dtlb_addr, else 0.
//  - rmPC/rmAddr hold until next exception; destRF/writeValRF hold, writeEnRF returns 0 when idle.
//  - FSM: RUN --accept&xcpt--> FLUSH (outputs pulsed) --> DRAIN (counter loaded DRAIN_CYCLES-1,
//    decrements each cycle) --cnt==0--> RUN. wb_ready=0 in FLUSH and DRAIN; wb_valid dropped.
//  - DRAIN_CYCLES=1: DRAIN lasts exactly one cycle. Total dead window = 1+DRAIN_CYCLES cycles.
//  - Reset mid-FLUSH/DRAIN: immediate return to RUN, pulses cleared, counter cleared.
//  - wb_valid=0: no state change, no pulses; xcpt_* inputs ignored.
// TESTING
//  1 Reset low, then accept {rf_wen=1,rd=5,data=32'hCAFE} -> next cycle writeEnRF=1,destRF=5,
//    writeValRF=32'hCAFE, retired_count=1.
//  2 Accept with xcpt_overflow, pc=32'h1040 -> xcpt_valid/flush/redirect pulse 1 cycle, rmPC=32'h1040,
//    rmAddr=0, writeEnRF=0, wb_ready=0 for 4 cycles (DRAIN_CYCLES=3), then 1.
//  3 Simultaneous xcpt_fetch(addr=32'hA000) and xcpt_dtlb(addr=32'hB000) -> rmAddr=32'hA000.
//  4 Back-to-back valid during drain with rf_wen=1 -> no writeEnRF, count unchanged.
//  5 Preload count to 32'hFFFF_FFFF via 2^32-1 retires (or force) + 1 retire -> retired_count=0.
//  6 Assert reset during DRAIN -> wb_ready=1, flush_pipeline=0 same cycle, next accept retires normally.

Source files
------------

// File: rtl/wb_xcpt_retire.sv
// Write-back / retire stage: drives the register-file write port, resolves
// exception priority across stages, pulses flush/redirect/save on an exception,
// blocks the input for a fixed drain window and counts retired instructions.
module wb_xcpt_retire #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter int unsigned          DATA_WIDTH   = 32,
  parameter int unsigned          RF_ADDR_W    = 5,
  parameter int unsigned          XCPT_ADDR_W  = 32,
  parameter logic [PC_WIDTH-1:0]  XCPT_HANDLER = 'h2000,
  parameter int unsigned          DRAIN_CYCLES = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic                   wb_rf_wen,
  input  logic [RF_ADDR_W-1:0]   wb_rd,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  input  logic [PC_WIDTH-1:0]    wb_pc,
  input  logic                   xcpt_fetch,
  input  logic [XCPT_ADDR_W-1:0] xcpt_fetch_addr,
  input  logic                   xcpt_illegal,
  input  logic                   xcpt_overflow,
  input  logic                   xcpt_dtlb,
  input  logic [XCPT_ADDR_W-1:0] xcpt_dtlb_addr,
  output logic                   writeEnRF,
  output logic [RF_ADDR_W-1:0]   destRF,
  output logic [DATA_WIDTH-1:0]  writeValRF,
  output logic                   xcpt_valid,
  output logic [PC_WIDTH-1:0]    rmPC,
  output logic [XCPT_ADDR_W-1:0] rmAddr,
  output logic                   flush_pipeline,
  output logic                   redirect_valid,
  output logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [31:0]            retired_count
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       drain_cnt_q, drain_cnt_d;
  logic                   wb_ready_q, wb_ready_d;
  logic                   wen_q, wen_d;
  logic [RF_ADDR_W-1:0]   dest_q, dest_d;
  logic [DATA_WIDTH-1:0]  wval_q, wval_d;
  logic                   xcpt_valid_q, xcpt_valid_d;
  logic [PC_WIDTH-1:0]    rm_pc_q, rm_pc_d;
  logic [XCPT_ADDR_W-1:0] rm_addr_q, rm_addr_d;
  logic                   flush_q, flush_d;
  logic                   redir_q, redir_d;
  logic [31:0]            retired_count_q, retired_count_d;

  logic                   accept;
  logic                   any_xcpt;
  logic [XCPT_ADDR_W-1:0] xcpt_addr_sel;

  assign accept   = wb_valid & wb_ready_q;
  assign any_xcpt = xcpt_fetch | xcpt_illegal | xcpt_overflow | xcpt_dtlb;

  // Faulting address of the oldest excepting stage; illegal/overflow carry none
  always_comb begin
    xcpt_addr_sel = '0;
    if (xcpt_fetch) begin
      xcpt_addr_sel = xcpt_fetch_addr;
    end else if (xcpt_illegal || xcpt_overflow) begin
      xcpt_addr_sel = '0;
    end else if (xcpt_dtlb) begin
      xcpt_addr_sel = xcpt_dtlb_addr;
    end
  end

  // Next-state and next-output logic for retire, exception and drain handling
  always_comb begin
    state_d         = state_q;
    drain_cnt_d     = drain_cnt_q;
    wen_d           = 1'b0;
    dest_d          = dest_q;
    wval_d          = wval_q;
    xcpt_valid_d    = 1'b0;
    rm_pc_d         = rm_pc_q;
    rm_addr_d       = rm_addr_q;
    flush_d         = 1'b0;
    redir_d         = 1'b0;
    retired_count_d = retired_count_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (any_xcpt) begin
            state_d      = ST_FLUSH;
            xcpt_valid_d = 1'b1;
            flush_d      = 1'b1;
            redir_d      = 1'b1;
            rm_pc_d      = wb_pc;
            rm_addr_d    = xcpt_addr_sel;
          end else begin
            wen_d           = wb_rf_wen;
            dest_d          = wb_rd;
            wval_d          = wb_data;
            retired_count_d = retired_count_q + 32'd1;
          end
        end
      end
      ST_FLUSH: begin
        state_d     = ST_DRAIN;
        drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = '0;
      end
    endcase

    wb_ready_d = (state_d == ST_RUN);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_RUN;
      drain_cnt_q     <= '0;
      wb_ready_q      <= 1'b1;
      wen_q           <= 1'b0;
      dest_q          <= '0;
      wval_q          <= '0;
      xcpt_valid_q    <= 1'b0;
      rm_pc_q         <= '0;
      rm_addr_q       <= '0;
      flush_q         <= 1'b0;
      redir_q         <= 1'b0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      drain_cnt_q     <= drain_cnt_d;
      wb_ready_q      <= wb_ready_d;
      wen_q           <= wen_d;
      dest_q          <= dest_d;
      wval_q          <= wval_d;
      xcpt_valid_q    <= xcpt_valid_d;
      rm_pc_q         <= rm_pc_d;
      rm_addr_q       <= rm_addr_d;
      flush_q         <= flush_d;
      redir_q         <= redir_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign wb_ready       = wb_ready_q;
  assign writeEnRF      = wen_q;
  assign destRF         = dest_q;
  assign writeValRF     = wval_q;
  assign xcpt_valid     = xcpt_valid_q;
  assign rmPC           = rm_pc_q;
  assign rmAddr         = rm_addr_q;
  assign flush_pipeline = flush_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = XCPT_HANDLER;
  assign retired_count  = retired_count_q;

endmodule
